// File: rtl/bus_transfer_sequencer_if.sv
// bus_transfer_sequencer_if: request, register-select and data-bus signals between the sequencer and the register file.
interface bus_transfer_sequencer_if #(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int NUM_REGS = 8
);
    logic req;
    logic [2:0] src;
    logic [2:0] dst;
    logic [DATA_BUS_WIDTH-1:0] bus_data;
    logic [DATA_BUS_WIDTH-1:0] xfer_data;
    logic ready;
    logic busy;
    logic done;
    logic [NUM_REGS-1:0] sel;
    logic [NUM_REGS-1:0] ld;
    modport master (input req, src, dst, bus_data, output ready, busy, sel, ld, xfer_data, done);
    modport slave (output req, src, dst, bus_data, input ready, busy, sel, ld, xfer_data, done);
endinterface

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: phased MOV8 register-to-register transfer driving one-hot select/load strobes on the data bus.
module bus_transfer_sequencer #(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int NUM_REGS = 8,
    parameter int PHASE_CYCLES = 1
) (
    input logic clock,
    input logic reset_n,
    bus_transfer_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, SELECT, LOAD, HOLD, RELEASE} state_t;
    state_t state, nxt;
    logic [3:0] cnt;
    logic [2:0] src_q, dst_q, src_n, dst_n;
    logic tc, accept;
    logic [NUM_REGS-1:0] sel_n, ld_n;
    assign tc = state == RELEASE || cnt == 4'(PHASE_CYCLES - 1);
    assign accept = state == IDLE && bus.req;
    assign src_n = accept ? bus.src : src_q;
    assign dst_n = accept ? bus.dst : dst_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= 4'd0;
            src_q <= 3'd0;
            dst_q <= 3'd0;
        end else begin
            state <= nxt;
            cnt <= (state == IDLE || tc) ? 4'd0 : cnt + 4'd1;
            src_q <= src_n;
            dst_q <= dst_n;
        end
    end
    always_comb begin
        nxt = state;
        if (state == IDLE)
            nxt = accept ? SELECT : IDLE;
        else if (tc)
            nxt = state == SELECT ? LOAD : state == LOAD ? HOLD : state == HOLD ? RELEASE : IDLE;
    end
    // Strobes are decoded from the next state so the registered outputs switch exactly at state boundaries.
    always_comb begin
        sel_n = '0;
        ld_n = '0;
        if ((nxt == SELECT || nxt == LOAD || nxt == HOLD) && src_n != dst_n)
            sel_n[src_n] = 1'b1;
        if (nxt == LOAD)
            ld_n[dst_n] = 1'b1;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.sel <= '0;
            bus.ld <= '0;
            bus.done <= 1'b0;
            bus.ready <= 1'b1;
            bus.busy <= 1'b0;
            bus.xfer_data <= {DATA_BUS_WIDTH{1'b0}};
        end else begin
            bus.sel <= sel_n;
            bus.ld <= ld_n;
            bus.done <= nxt == RELEASE;
            bus.ready <= nxt == IDLE;
            bus.busy <= nxt != IDLE;
            if (state == LOAD && tc)
                bus.xfer_data <= bus.bus_data;
        end
    end
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb_bus_transfer_sequencer: drives one-phase and three-phase sequencers with shared stimulus; a per-instance scoreboard checks every cycle.
module tb_bus_transfer_sequencer;
    logic clock = 1'b0;
    logic reset_n;
    logic req;
    logic [2:0] src, dst;
    logic [7:0] bus_data;
    logic [7:0] sel_o[2], ld_o[2], xfer_o[2];
    logic done_o[2], ready_o[2], busy_o[2];
    int total = 0;
    int bad = 0;
    always #5 clock = ~clock;
    task automatic chk(input string n, input int g, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", n, g, $time, a, e);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int P = g ? 3 : 1;
        bus_transfer_sequencer_if #(.DATA_BUS_WIDTH(8), .NUM_REGS(8)) b ();
        bus_transfer_sequencer #(.DATA_BUS_WIDTH(8), .NUM_REGS(8), .PHASE_CYCLES(P)) dut (
            .clock(clock),
            .reset_n(reset_n),
            .bus(b)
        );
        assign b.req = req;
        assign b.src = src;
        assign b.dst = dst;
        assign b.bus_data = bus_data;
        assign sel_o[g] = b.sel;
        assign ld_o[g] = b.ld;
        assign xfer_o[g] = b.xfer_data;
        assign done_o[g] = b.done;
        assign ready_o[g] = b.ready;
        assign busy_o[g] = b.busy;
        bit act;
        int c;
        logic [2:0] s_q[$], d_q[$];
        logic [7:0] x_q[$];
        // Reference: c counts cycles since acceptance; select spans 3P cycles, load the middle P, done at 3P+1.
        always @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                act = 0;
                c = 0;
                s_q.delete();
                d_q.delete();
                x_q.delete();
            end else if (act) begin
                if (c == 2 * P) x_q.push_back(bus_data);
                c++;
                if (c > 3 * P + 1) act = 0;
            end else if (req) begin
                act = 1;
                c = 1;
                s_q.push_back(src);
                d_q.push_back(dst);
            end
        end
        always @(negedge clock) begin : mon
            logic [7:0] es, el, xe;
            if (reset_n) begin
                es = 8'd0;
                el = 8'd0;
                if (act && s_q.size() > 0) begin
                    if (c <= 3 * P && s_q[0] != d_q[0]) es[s_q[0]] = 1'b1;
                    if (c > P && c <= 2 * P) el[d_q[0]] = 1'b1;
                end
                chk("sel", g, 32'(b.sel), 32'(es));
                chk("ld", g, 32'(b.ld), 32'(el));
                chk("done", g, 32'(b.done), 32'(act && c == 3 * P + 1));
                chk("ready", g, 32'(b.ready), 32'(!act));
                chk("busy", g, 32'(b.busy), 32'(act));
                chk("onehot", g, 32'($countones(b.sel) <= 1 && $countones(b.ld) <= 1), 32'd1);
                if (b.done) begin
                    chk("pending", g, 32'(x_q.size()), 32'd1);
                    if (x_q.size() > 0) begin
                        xe = x_q.pop_front();
                        chk("xfer", g, 32'(b.xfer_data), 32'(xe));
                    end
                    if (s_q.size() > 0) begin
                        void'(s_q.pop_front());
                        void'(d_q.pop_front());
                    end
                end
            end
        end
    end
    initial begin
        reset_n = 1'b0;
        req = 1'b0;
        src = 3'd0;
        dst = 3'd0;
        bus_data = 8'd0;
        cyc(2);
        for (int i = 0; i < 2; i++) begin
            chk("rst_sel", i, 32'(sel_o[i]), 32'd0);
            chk("rst_ready", i, 32'(ready_o[i]), 32'd1);
            chk("rst_busy", i, 32'(busy_o[i]), 32'd0);
            chk("rst_xfer", i, 32'(xfer_o[i]), 32'd0);
        end
        reset_n = 1'b1;
        cyc(1);
        src = 3'd1; dst = 3'd2; bus_data = 8'hA5; req = 1'b1;
        cyc(1);
        req = 1'b0;
        cyc(12);
        for (int i = 0; i < 2; i++) chk("basic_xfer", i, 32'(xfer_o[i]), 32'hA5);
        src = 3'd1; dst = 3'd2; bus_data = 8'h5A; req = 1'b1;
        cyc(1);
        req = 1'b0;
        @(posedge clock);
        #2;
        chk("pre_rst_ld", 0, 32'(ld_o[0]), 32'h04);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("mid_rst_sel", i, 32'(sel_o[i]), 32'd0);
            chk("mid_rst_ld", i, 32'(ld_o[i]), 32'd0);
            chk("mid_rst_done", i, 32'(done_o[i]), 32'd0);
            chk("mid_rst_ready", i, 32'(ready_o[i]), 32'd1);
            chk("mid_rst_xfer", i, 32'(xfer_o[i]), 32'd0);
        end
        #1;
        reset_n = 1'b1;
        cyc(2);
        src = 3'd6; dst = 3'd0; req = 1'b1;
        cyc(1);
        req = 1'b0;
        repeat (12) begin bus_data = 8'($urandom); cyc(1); end
        src = 3'd3; dst = 3'd3; bus_data = 8'd0; req = 1'b1;
        cyc(1);
        req = 1'b0;
        cyc(12);
        src = 3'd0; dst = 3'd1; bus_data = 8'($urandom); req = 1'b1;
        cyc(1);
        req = 1'b0;
        cyc(2);
        src = 3'd4; dst = 3'd5; req = 1'b1;
        cyc(1);
        req = 1'b0;
        cyc(12);
        src = 3'd0; dst = 3'd1; req = 1'b1;
        cyc(1);
        src = 3'd2; dst = 3'd3;
        repeat (24) begin bus_data = 8'($urandom); cyc(1); end
        req = 1'b0;
        cyc(12);
        repeat (400) begin
            req = $urandom_range(0, 2) == 0;
            src = 3'($urandom);
            dst = $urandom_range(0, 5) == 0 ? src : 3'($urandom);
            bus_data = 8'($urandom);
            cyc(1);
        end
        req = 1'b0;
        cyc(12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
